keypad_cmd: RTL

KEYPAD_CMD -- requirements
Module: keypad_cmd

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/cmd_fifo.sv | 62 ++++++
 rtl/keypad_cmd.sv | 103 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared command encodings and keypad key codes for the keypad command path.
// map_key turns a 4-bit key code into a game command (CMD_NONE = discard).
package keypad_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_BOMB  = 3'd5,
        CMD_PAUSE = 3'd6
    } cmd_t;

    localparam int CMD_W = 3;

    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_DOWN  = 4'd8;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_BOMB  = 4'd5;
    localparam logic [3:0] KEY_PAUSE = 4'd0;

    function automatic cmd_t map_key(input logic [3:0] code);
        cmd_t c;
        case (code)
            KEY_UP:    c = CMD_UP;
            KEY_DOWN:  c = CMD_DOWN;
            KEY_LEFT:  c = CMD_LEFT;
            KEY_RIGHT: c = CMD_RIGHT;
            KEY_BOMB:  c = CMD_BOMB;
            KEY_PAUSE: c = CMD_PAUSE;
            default:   c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO: head is read combinationally from a
// small register file; a push into a full FIFO only lands if a pop frees a slot.
module cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [4:0]       level
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [4:0]       level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == 5'(FIFO_DEPTH));
    assign empty   = (level_reg == 5'd0);
    assign level   = level_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Forced to zero when empty so the head reads 0 after reset without clearing storage.
    assign rdata   = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= 5'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 5'd1;
                2'b01:   level_reg <= level_reg - 5'd1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/keypad_cmd.sv
// Debounces the keypad scanner's sticky key code, turns changes of the accepted
// key into game commands and queues them for the consumer.
module keypad_cmd
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] decode,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [4:0] level,
    output logic       overflow
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    logic [3:0]    sync1_reg;
    logic [3:0]    sync_reg;
    logic [3:0]    candidate_reg;
    logic [CW-1:0] counter_reg;
    logic [3:0]    accepted_reg;
    logic          baseline_reg;
    cmd_t          cmd_reg;
    logic          push_reg;
    logic          overflow_reg;

    logic          stable;
    logic          accept;
    logic          key_event;
    cmd_t          mapped;
    logic          fifo_full;
    logic          fifo_empty;

    assign stable    = (sync_reg == candidate_reg);
    // Saturation at STABLE_CYCLES guarantees this fires once per stable period.
    assign accept    = stable && (counter_reg == CNT_ACC);
    assign key_event = accept && baseline_reg && (candidate_reg != accepted_reg);
    assign mapped    = map_key(candidate_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg     <= 4'd0;
            sync_reg      <= 4'd0;
            candidate_reg <= 4'd0;
            counter_reg   <= '0;
            accepted_reg  <= 4'd0;
            baseline_reg  <= 1'b0;
            cmd_reg       <= CMD_NONE;
            push_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            sync1_reg <= decode;
            sync_reg  <= sync1_reg;

            if (!stable) begin
                candidate_reg <= sync_reg;
                counter_reg   <= '0;
            end else if (counter_reg != CNT_SAT) begin
                counter_reg <= counter_reg + CW'(1);
            end

            // First acceptance after reset only establishes the baseline key.
            if (accept) begin
                baseline_reg <= 1'b1;
                accepted_reg <= candidate_reg;
            end

            push_reg <= key_event && (mapped != CMD_NONE);
            if (key_event) begin
                cmd_reg <= mapped;
            end

            if (push_reg && fifo_full && !cmd_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_reg),
        .wdata (cmd_reg),
        .pop   (cmd_ready),
        .rdata (cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign cmd_valid = !fifo_empty;
    assign overflow  = overflow_reg;

endmodule
